regbank_write: RTL and testbench
================================

REGBANK_WRITE -- requirements
Module: regbank_write

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: bus  input  16  value currently driven on the shared datapath bus.
REQ-004 SHALL have port: wr_sel  input  [0:9]  one-hot destination select: bit0 IR, bits1-7 r0..r6, bit8 pc, bit9 A.
REQ-005 SHALL have port: pc_incr  input  1  increment program counter this cycle.
REQ-006 SHALL have port: g_in  input  16  ALU result.
REQ-007 SHALL have port: g_load  input  1  load g_in into G.
REQ-008 SHALL have port: clr_err  input  1  synchronous clear of sel_err.
REQ-009 SHALL have ports: r0..r6  output  16 each  general registers.
REQ-010 SHALL have port: pc  output  6  program counter.
REQ-011 SHALL have ports: ir, a, g  output  16 each  instruction, ALU operand A and ALU result registers.
REQ-012 SHALL have port: wr_ack  output  1  one-cycle pulse confirming a completed bus write.
REQ-013 SHALL have port: wr_dest  output  4  index (0-9, bit position in wr_sel) of the last completed bus write.
REQ-014 SHALL have port: sel_err  output  1  sticky flag, wr_sel had more than one bit set.

Function
REQ-015 SHALL, on a rising edge with wr_sel exactly one-hot, load bus into the selected register only; all other bus-writable registers hold.
REQ-016 SHALL, for a pc write, load bus[5:0] into pc; bus[15:6] ignored.
REQ-017 SHALL, with wr_sel = 0, perform no bus write and leave wr_ack low next cycle.
REQ-018 SHALL, with more than one wr_sel bit set, perform no bus write, leave wr_ack low, and set sel_err at that edge.
REQ-019 SHALL hold sel_err at 1 until clr_err is sampled high or reset; if clr_err and a new multi-hot wr_sel occur at the same edge, sel_err stays 1.
REQ-020 SHALL, on pc_incr with no pc write, update pc to pc+1 modulo 64 (63 wraps to 0).
REQ-021 SHALL give a pc write priority over pc_incr at the same edge (pc = bus[5:0], no increment).
REQ-022 SHALL, on g_load, load g_in into g independent of wr_sel; G is not bus-writable.
REQ-023 SHALL assert wr_ack for exactly one cycle, registered, in the cycle after each valid one-hot write; consecutive writes on consecutive cycles give wr_ack high on consecutive cycles.
REQ-024 SHALL update wr_dest at the same edge as wr_ack rises and hold it until the next valid write.
REQ-025 SHALL make every written value visible on its output port one cycle after the write edge (one-cycle latency), with no combinational path from bus to any output.
REQ-026 SHALL treat bus writes, pc_incr, g_load and clr_err as independent events that may all occur at the same edge.

Reset
REQ-027 SHALL, while resetn is low, force r0..r6, ir, a, g to 16'h0000, pc to 0, wr_dest to 0, wr_ack and sel_err to 0, asynchronously, regardless of clock.
REQ-028 SHALL, when reset is asserted mid-operation, discard any write in progress; the first write after deassertion completes normally at the next rising edge.

Verification
REQ-029 SHALL cover: reset, then wr_sel=bit3, bus=16'hBEEF -> r2=16'hBEEF next cycle, wr_ack pulses once, wr_dest=3, all other registers 0.
REQ-030 SHALL cover: pc=63, pc_incr=1 -> pc=0; pc=5, pc_incr=1 with wr_sel=bit8, bus=16'hFF2A -> pc=6'h2A.
REQ-031 SHALL cover: wr_sel=bits1+2, bus=16'h1234 -> r0, r1 unchanged, wr_ack=0, sel_err=1 and held; clr_err=1 one cycle -> sel_err=0.
REQ-032 SHALL cover: g_load=1, g_in=16'h00FF together with wr_sel=bit9, bus=16'h0F0F -> g=16'h00FF, a=16'h0F0F, wr_dest=9.
REQ-033 SHALL cover: back-to-back writes r0=1, r1=2, r2=3 on three cycles -> wr_ack high three consecutive cycles, wr_dest 1,2,3.
REQ-034 SHALL cover: resetn pulsed low between clock edges after r5=16'hAAAA -> r5=0 and wr_ack=0 immediately, before the next edge.

Source files
------------

// File: rtl/regbank_write_if.sv
// regbank_write_if: datapath bus, write select, control strobes and register outputs of the writeback bank
interface regbank_write_if;
   logic [15:0] bus;
   logic [0:9]  wr_sel;
   logic        pc_incr;
   logic [15:0] g_in;
   logic        g_load;
   logic        clr_err;
   logic [15:0] r0, r1, r2, r3, r4, r5, r6;
   logic [15:0] ir, a, g;
   logic [5:0]  pc;
   logic        wr_ack;
   logic [3:0]  wr_dest;
   logic        sel_err;

   modport master (
      output bus, wr_sel, pc_incr, g_in, g_load, clr_err,
      input  r0, r1, r2, r3, r4, r5, r6, ir, a, g, pc, wr_ack, wr_dest, sel_err
   );

   modport slave (
      input  bus, wr_sel, pc_incr, g_in, g_load, clr_err,
      output r0, r1, r2, r3, r4, r5, r6, ir, a, g, pc, wr_ack, wr_dest, sel_err
   );
endinterface

// File: rtl/regbank_write.sv
// regbank_write: one-hot bus writeback into IR, r0..r6, pc and A, plus G load, pc increment and sticky select error
module regbank_write (
   input logic            clock,
   input logic            resetn,
   regbank_write_if.slave bif
);
   logic [15:0] ir_q, ir_d, a_q, a_d, g_q, g_d;
   logic [15:0] r_q [7];
   logic [15:0] r_d [7];
   logic [5:0]  pc_q, pc_d;
   logic        wr_ack_q, wr_ack_d, sel_err_q, sel_err_d;
   logic [3:0]  wr_dest_q, wr_dest_d, sel_idx;
   logic        sel_any, sel_multi, sel_one, pc_wr;

   // classify the select word (x & (x-1) is nonzero exactly when two or more bits are set) and encode its position
   always_comb begin
      sel_any   = |bif.wr_sel;
      sel_multi = |(bif.wr_sel & (bif.wr_sel - 10'd1));
      sel_one   = sel_any & ~sel_multi;
      sel_idx   = '0;
      for (int i = 0; i < 10; i++) sel_idx = bif.wr_sel[i] ? 4'(i) : sel_idx;
      pc_wr     = sel_one & bif.wr_sel[8];
   end

   // next state: only a clean one-hot select writes; a pc write overrides the increment
   always_comb begin
      ir_d = (sel_one && bif.wr_sel[0]) ? bif.bus : ir_q;
      for (int i = 0; i < 7; i++) r_d[i] = (sel_one && bif.wr_sel[i + 1]) ? bif.bus : r_q[i];
      a_d       = (sel_one && bif.wr_sel[9]) ? bif.bus : a_q;
      pc_d      = pc_wr ? bif.bus[5:0] : bif.pc_incr ? pc_q + 6'd1 : pc_q;
      g_d       = bif.g_load ? bif.g_in : g_q;
      wr_ack_d  = sel_one;
      wr_dest_d = sel_one ? sel_idx : wr_dest_q;
      sel_err_d = sel_multi | (sel_err_q & ~bif.clr_err);
   end

   // state registers, cleared asynchronously so a write in flight at reset is dropped
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ir_q      <= '0;
         r_q       <= '{default: '0};
         a_q       <= '0;
         g_q       <= '0;
         pc_q      <= '0;
         wr_ack_q  <= 1'b0;
         wr_dest_q <= '0;
         sel_err_q <= 1'b0;
      end else begin
         ir_q      <= ir_d;
         r_q       <= r_d;
         a_q       <= a_d;
         g_q       <= g_d;
         pc_q      <= pc_d;
         wr_ack_q  <= wr_ack_d;
         wr_dest_q <= wr_dest_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign bif.ir      = ir_q;
   assign bif.r0      = r_q[0];
   assign bif.r1      = r_q[1];
   assign bif.r2      = r_q[2];
   assign bif.r3      = r_q[3];
   assign bif.r4      = r_q[4];
   assign bif.r5      = r_q[5];
   assign bif.r6      = r_q[6];
   assign bif.a       = a_q;
   assign bif.g       = g_q;
   assign bif.pc      = pc_q;
   assign bif.wr_ack  = wr_ack_q;
   assign bif.wr_dest = wr_dest_q;
   assign bif.sel_err = sel_err_q;
endmodule

// File: tb/tb_regbank_write.sv
// tb_regbank_write: scoreboard bench with a destination-indexed reference model of the register bank
module tb_regbank_write;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   regbank_write_if bif ();

   regbank_write dut (.clock(clock), .resetn(resetn), .bif(bif));

   always #5 clock = ~clock;

   typedef struct packed {
      logic [9:0][15:0] v;
      logic [15:0]      g;
      logic             ack;
      logic [3:0]       dest;
      logic             err;
   } snap_t;

   snap_t m;
   snap_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   function automatic string nm(int i);
      return i == 0 ? "ir" : i == 8 ? "pc" : i == 9 ? "a" : $sformatf("r%0d", i - 1);
   endfunction

   function automatic logic [15:0] dut_v(int i);
      case (i)
         0: return bif.ir;
         1: return bif.r0;
         2: return bif.r1;
         3: return bif.r2;
         4: return bif.r3;
         5: return bif.r4;
         6: return bif.r5;
         7: return bif.r6;
         8: return {10'd0, bif.pc};
         default: return bif.a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   task automatic chk_snap(input string tag, input snap_t e);
      for (int i = 0; i < 10; i++) chk({tag, nm(i)}, dut_v(i), e.v[i]);
      chk({tag, "g"}, bif.g, e.g);
      chk({tag, "wr_ack"}, 16'(bif.wr_ack), 16'(e.ack));
      chk({tag, "wr_dest"}, 16'(bif.wr_dest), 16'(e.dest));
      chk({tag, "sel_err"}, 16'(bif.sel_err), 16'(e.err));
   endtask

   // reference behaviour of one rising edge, expressed per destination index
   task automatic model_edge(input logic [0:9] s, input logic [15:0] b, input logic pi,
                             input logic gl, input logic [15:0] gi, input logic ce);
      int n = 0;
      int k = 0;
      for (int i = 0; i < 10; i++) if (s[i]) begin n++; k = i; end
      if (n == 1) m.v[k] = (k == 8) ? (b % 64) : b;
      if (pi && !(n == 1 && k == 8)) m.v[8] = (m.v[8] + 1) % 64;
      if (gl) m.g = gi;
      m.ack = (n == 1);
      if (n == 1) m.dest = 4'(k);
      if (n > 1) m.err = 1'b1;
      else if (ce) m.err = 1'b0;
   endtask

   task automatic step(input logic [0:9] s, input logic [15:0] b, input logic pi,
                       input logic gl, input logic [15:0] gi, input logic ce);
      bif.wr_sel = s; bif.bus = b; bif.pc_incr = pi;
      bif.g_load = gl; bif.g_in = gi; bif.clr_err = ce;
      @(posedge clock);
      model_edge(s, b, pi, gl, gi, ce);
      exp_q.push_back(m);
      #1;
   endtask

   function automatic logic [0:9] oh(int k);
      logic [0:9] s = '0;
      s[k] = 1'b1;
      return s;
   endfunction

   // monitor: every falling edge the DUT presents a settled register image for the previous write edge
   always @(negedge clock) begin
      if (exp_q.size() > 0) chk_snap("", exp_q.pop_front());
   end

   initial begin
      logic [0:9] s;
      int r, k;
      m = '0;
      bif.wr_sel = '0; bif.bus = '0; bif.pc_incr = 0; bif.g_load = 0; bif.g_in = '0; bif.clr_err = 0;
      #2 chk_snap("rst_", m);
      @(posedge clock);
      #1 resetn = 1'b1;
      step(oh(3), 16'hBEEF, 0, 0, 0, 0);
      step('0, 16'h5555, 0, 0, 0, 0);
      step(oh(8), 16'h003F, 0, 0, 0, 0);
      step('0, 16'h0000, 1, 0, 0, 0);
      step(oh(8), 16'h0005, 0, 0, 0, 0);
      step(oh(8), 16'hFF2A, 1, 0, 0, 0);
      step(oh(1) | oh(2), 16'h1234, 0, 0, 0, 0);
      step('0, 16'h1234, 0, 0, 0, 0);
      step('0, 16'h0000, 0, 0, 0, 1);
      step(oh(4) | oh(9), 16'h4321, 0, 0, 0, 1);
      step('0, 16'h0000, 0, 0, 0, 1);
      step(oh(9), 16'h0F0F, 0, 1, 16'h00FF, 0);
      step(oh(1), 16'h0001, 0, 0, 0, 0);
      step(oh(2), 16'h0002, 0, 0, 0, 0);
      step(oh(3), 16'h0003, 0, 0, 0, 0);
      step(oh(6), 16'hAAAA, 0, 0, 0, 0);
      @(negedge clock);
      #2 resetn = 1'b0;
      #1 m = '0;
      chk_snap("async_", m);
      #1 resetn = 1'b1;
      step(oh(1), 16'h0007, 0, 0, 0, 0);
      for (int t = 0; t < 400; t++) begin
         r = $urandom_range(0, 9);
         k = $urandom_range(0, 9);
         s = r < 2 ? '0 : r < 8 ? oh(k) : (10'($urandom) | oh(k) | oh((k + 1 + $urandom_range(0, 8)) % 10));
         step(s, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      step('0, 16'h0000, 0, 0, 0, 0);
      repeat (2) @(negedge clock);
      #1 chk("drain", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
